// File: rtl/addsub_serial.sv
// Bit-serial adder/subtractor: one full adder resolves one bit per clock, LSB first.
// START/BUSY/DONE handshake; SUM and flags are registered and held between operations.
module fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module addsub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             OVERFLOW,
    output logic             ZERO
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PEN  = CW'(WIDTH - 2);

    // Encoding chosen so BUSY and DONE are bits of the state register.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             r_cin_msb;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;

    logic             w_s;
    logic             w_co;
    logic             w_load;
    logic             w_run;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    fa u_fa (
        .i_a     (r_opa[0]),
        .i_b     (r_opb[0]),
        .i_c     (r_c),
        .o_sum   (w_s),
        .o_carry (w_co)
    );

    assign w_run     = (r_state == S_RUN);
    assign w_load    = START && ((r_state == S_IDLE) || (r_state == S_FIN));
    assign w_last    = w_run && (r_cnt == LAST);
    assign w_res_nxt = {w_s, r_res[WIDTH-1:1]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (START) w_state_nxt = S_RUN;
            S_RUN:  if (r_cnt == LAST) w_state_nxt = S_FIN;
            S_FIN:  w_state_nxt = START ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_opa     <= '0;
            r_opb     <= '0;
            r_res     <= '0;
            r_cnt     <= '0;
            r_c       <= 1'b0;
            r_cin_msb <= 1'b0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b1;
        end else if (w_load) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            r_opa     <= A;
            r_opb     <= SUB ? ~B : B;
            r_c       <= SUB;
            r_cnt     <= '0;
            r_res     <= '0;
            r_cin_msb <= 1'b0;
        end else if (w_run) begin
            r_opa <= r_opa >> 1;
            r_opb <= r_opb >> 1;
            r_res <= w_res_nxt;
            r_c   <= w_co;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == PEN) begin
                r_cin_msb <= w_co;
            end
            if (w_last) begin
                r_sum   <= w_res_nxt;
                r_carry <= w_co;
                r_ovf   <= r_cin_msb ^ w_co;
                r_zero  <= (w_res_nxt == '0);
            end
        end
    end

    assign BUSY     = r_state[0];
    assign DONE     = r_state[1];
    assign SUM      = r_sum;
    assign CARRY    = r_carry;
    assign OVERFLOW = r_ovf;
    assign ZERO     = r_zero;
endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: WIDTH=8 main instance plus a WIDTH=4 instance.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_addsub_serial;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic       sub8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, carry8, ovf8, zero8;
    logic [7:0] sum8;

    logic       start4 = 1'b0;
    logic       sub4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4, done4, carry4, ovf4, zero4;
    logic [3:0] sum4;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] held8 = 8'h00;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .START(start8), .SUB(sub8),
        .A(a8), .B(b8), .BUSY(busy8), .DONE(done8), .SUM(sum8),
        .CARRY(carry8), .OVERFLOW(ovf8), .ZERO(zero8)
    );

    addsub_serial #(.WIDTH(4)) dut4 (
        .CLK(clk), .RST(rst), .START(start4), .SUB(sub4),
        .A(a4), .B(b4), .BUSY(busy4), .DONE(done4), .SUM(sum4),
        .CARRY(carry4), .OVERFLOW(ovf4), .ZERO(zero4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Busy phase: WIDTH falling edges with BUSY=1, DONE=0, SUM held.
    task automatic busy_phase8(input string tag);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) start8 = 1'b0;
            chk({tag, "_busy"}, {busy8, done8}, 2'b10);
            chk({tag, "_hold"}, sum8, held8);
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic sub,
                       input logic [7:0] es, input logic ec,
                       input logic eo, input logic ez);
        @(negedge clk);
        a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
        busy_phase8(tag);
        @(negedge clk);
        chk({tag, "_done"}, {busy8, done8}, 2'b01);
        chk({tag, "_sum"}, sum8, es);
        chk({tag, "_flags"}, {carry8, ovf8, zero8}, {ec, eo, ez});
        held8 = es;
        @(negedge clk);
        chk({tag, "_idle"}, {busy8, done8}, 2'b00);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst8_ctl", {busy8, done8}, 2'b00);
        chk("rst8_out", {sum8, carry8, ovf8, zero8}, {8'h00, 3'b001});
        chk("rst4_out", {busy4, done4, sum4, carry4, ovf4, zero4},
            {2'b00, 4'h0, 3'b001});
        rst = 1'b0;

        op8("add_3c_1e", 8'h3C, 8'h1E, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        op8("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        op8("sub_42_42", 8'h42, 8'h42, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

        // START pulsed mid-run must not disturb the operation in flight.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) start8 = 1'b0;
            if (k == 2) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
            end
            if (k == 3) start8 = 1'b0;
            chk("ign_busy", {busy8, done8}, 2'b10);
        end
        @(negedge clk);
        chk("ign_done", {busy8, done8}, 2'b01);
        chk("ign_sum", sum8, 8'h30);
        chk("ign_flags", {carry8, ovf8, zero8}, 3'b000);
        held8 = 8'h30;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("ign_quiet", {busy8, done8, sum8}, {2'b00, 8'h30});
        end

        // Back-to-back with START held high across both operations.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("b2b1_busy", {busy8, done8}, 2'b10);
        end
        @(negedge clk);
        chk("b2b1_done", {busy8, done8, sum8}, {2'b01, 8'h02});
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("b2b2_busy", {busy8, done8, sum8}, {2'b10, 8'h02});
        end
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b2_done", {busy8, done8, sum8}, {2'b01, 8'h02});
        @(negedge clk);
        chk("b2b_idle", {busy8, done8}, 2'b00);
        held8 = 8'h02;

        // Reset in the middle of a run after loading 0x5A.
        op8("pre_rst", 8'h3C, 8'h1E, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0; start8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) start8 = 1'b0;
            chk("rmid_busy", {busy8, done8, sum8}, {2'b10, 8'h5A});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rmid_ctl", {busy8, done8}, 2'b00);
        chk("rmid_out", {sum8, carry8, ovf8, zero8}, {8'h00, 3'b001});
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rmid_nodone", {busy8, done8, sum8}, {2'b00, 8'h00});
        end

        // WIDTH=4: 0xF + 0x1 wraps to zero with carry.
        @(negedge clk);
        a4 = 4'hF; b4 = 4'h1; sub4 = 1'b0; start4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) start4 = 1'b0;
            chk("w4_busy", {busy4, done4}, 2'b10);
        end
        @(negedge clk);
        chk("w4_done", {busy4, done4}, 2'b01);
        chk("w4_res", {sum4, carry4, ovf4, zero4}, {4'h0, 3'b101});
        @(negedge clk);
        chk("w4_idle", {busy4, done4}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised bit-serial adder/subtractor for the SAP datapath. It resolves one bit per clock, LSB first, through a single `fa` instance, so a WIDTH-bit add or subtract costs one full adder plus shift registers. A START/BUSY/DONE handshake controls each operation. Results and flags (carry, overflow, zero) are registered and held until the next operation completes.

## Interface
- WIDTH, 8: operand and result width in bits; legal range WIDTH ≥ 2.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only while idle or while DONE is high.
- SUB  input  1  mode, captured with START: 0 computes A+B, 1 computes A−B.
- A  input  WIDTH  operand A, captured with START.
- B  input  WIDTH  operand B, captured with START.
- BUSY  output  1  high while bits are being computed.
- DONE  output  1  one-cycle pulse; SUM and the flags are updated in this cycle.
- SUM  output  WIDTH  result of the last completed operation.
- CARRY  output  1  carry out of the MSB. For SUB this is the not-borrow: 1 when A ≥ B unsigned.
- OVERFLOW  output  1  two's-complement overflow: carry into the MSB XOR carry out of the MSB.
- ZERO  output  1  SUM == 0.

## Operation
- States:
  - IDLE: BUSY=0, DONE=0.
  - RUN: BUSY=1.
  - FIN: DONE=1, BUSY=0.
- IDLE → RUN when START=1. On that edge:
  - opA ← A.
  - opB ← B when SUB=0, or ~B when SUB=1.
  - carry register c ← SUB.
  - bit counter ← 0.
  - result shift register cleared.
- RUN, every edge:
  - fa inputs are opA[0], opB[0] and c.
  - The fa SUM bit shifts into the result register at bit WIDTH−1; the register shifts right.
  - c ← fa CARRY.
  - opA and opB shift right by one.
  - counter increments.
  - Before the MSB step, c is copied to an internal cin_msb register.
- RUN → FIN on the edge that processes bit WIDTH−1 (counter == WIDTH−1). On that same edge:
  - SUM ← completed result.
  - CARRY ← final carry.
  - OVERFLOW ← cin_msb XOR final carry.
  - ZERO ← (completed result == 0).
- FIN → RUN when START=1, with a full capture as in IDLE (back-to-back operation). FIN → IDLE otherwise.
- START is ignored in RUN; operands, SUB and the operation in flight are unaffected.
- SUM and the flags change only on the edge entering FIN or on reset. They are stable at all other times, including throughout RUN.
- Counter width is $clog2(WIDTH). Counter and opA/opB contents are don't-care in IDLE.

## Timing
- Reset: state IDLE; BUSY, DONE, SUM, CARRY and OVERFLOW are 0. ZERO is 1, consistent with SUM=0.
- RST has priority over START and over every state. Asserting RST mid-RUN aborts the operation: no DONE pulse, and outputs take their reset values on that edge.
- Latency, with START sampled at edge 0:
  - BUSY is high after edges 0 through WIDTH−1 (WIDTH cycles).
  - DONE and the results are valid after edge WIDTH.
- Throughput is one operation per WIDTH+1 cycles when START is held high or reasserted during DONE.
- DONE is exactly one cycle wide. BUSY and DONE are never high together.
- Outputs come straight from registers; there is no combinational path from inputs to outputs.

## Test plan
- Add, WIDTH=8: A=0x3C, B=0x1E, SUB=0, START one cycle. Required: BUSY high for 8 cycles, then DONE with SUM=0x5A, CARRY=0, OVERFLOW=0, ZERO=0.
- Add boundaries:
  - 0x7F+0x01 → SUM=0x80, OVERFLOW=1, CARRY=0.
  - 0xFF+0x01 → SUM=0x00, CARRY=1, ZERO=1, OVERFLOW=0.
- Subtract:
  - 0x05−0x07 → SUM=0xFE, CARRY=0, OVERFLOW=0.
  - 0x80−0x01 → SUM=0x7F, CARRY=1, OVERFLOW=1.
  - 0x42−0x42 → SUM=0x00, ZERO=1, CARRY=1.
- Ignore while busy: start 0x10+0x20. Three cycles later pulse START with A=0xFF, B=0xFF, SUB=1. Required: single DONE, SUM=0x30; no second operation.
- Back-to-back: hold START high with 0x01+0x01 for both operations. Required: DONE pulses 9 cycles apart, each SUM=0x02; SUM stays 0x02 throughout the second RUN.
- Reset mid-op: load a prior result of 0x5A, start a new operation, assert RST after 4 RUN cycles. Required on that edge: BUSY=0, SUM=0x00, ZERO=1, and no DONE follows. Also run a WIDTH=4 instance with 0xF+0x1 → SUM=0x0, CARRY=1, DONE 4 cycles after START.
